nihilist_stream_ctrl: RTL
=========================

// Module: nihilist_stream_ctrl
// PURPOSE
// - Sequencing controller for the Nihilist/Polybius decrypt datapath: accepts a ciphertext byte stream,
//   cycles the secret key per character, decodes one character per cycle, emits a plaintext stream.
// - Owns the programmable key store and message framing (start/last/done). Sits between ingress FIFO and text sink.
// PARAMETERS
// - MAX_KEY  9  key store depth; key_len legal range 1..MAX_KEY
// - KIW      4  key index / key_len width, >= clog2(MAX_KEY+1)
// PORTS
// - clk        in   1    clock; all state updates on rising edge
// - rst_n      in   1    asynchronous active-low reset
// - start      in   1    pulse: begin a message (honoured only in IDLE)
// - busy       out  1    high in RUN and FLUSH
// - done       out  1    one-cycle pulse after last plaintext char handshakes
// - key_we     in   1    key char write strobe (honoured only in IDLE)
// - key_addr   in   KIW  key position 0..MAX_KEY-1
// - key_data   in   8    ASCII key char, must be in the 5x5 table
// - key_len_we in   1    key length write strobe (IDLE only)
// - key_len_in in   KIW  new key length
// - cfg_err    out  1    one-cycle pulse: rejected config write
// - in_valid/in_ready  in/out 1  ciphertext handshake
// - in_data    in   8    ciphertext value (row*10+col sum, 22..110 nominal)
// - in_last    in   1    marks final ciphertext char of message
// - out_valid/out_ready out/in 1 plaintext handshake
// - out_data   out  8    plaintext ASCII
// - out_last   out  1    accompanies final plaintext char
// - out_err    out  1    char failed decode; out_data = 8'h3F ('?')
// - err_cnt    out  8    saturating count of decode errors in current message
// BEHAVIOUR
// - Reset: state IDLE; busy, done, cfg_err, in_ready, out_valid, out_last, out_err = 0; out_data, err_cnt = 0;
//   key_idx = 0; key store = "PARASCHIV", key_len = 9 (MAX_KEY < 9: first MAX_KEY chars, key_len = MAX_KEY).
// - Handshake: transfer when valid && ready same edge. out_valid held, data stable until out_ready.
// - in_ready = (state==RUN) && (!out_valid || out_ready). One output register; latency 1 cycle; full throughput.
// - States: IDLE -start-> RUN (key_idx=0, err_cnt=0). RUN -accept in_last-> FLUSH (in_ready=0).
//   FLUSH -out_last handshake-> IDLE, done pulses next cycle. start while busy ignored.
// - Decode per accepted byte: ksum = 10*row(key[key_idx]) + col(key[key_idx]); d = in_data - ksum (8-bit,
//   compare as unsigned before subtract: in_data < ksum is error); r = d/10, c = d%10; error if r or c not 1..5.
//   Valid -> out_data = table[r][c], out_err=0. Error -> 8'h3F, out_err=1, err_cnt++ (saturates at 255).
// - key_idx increments per accepted char; wraps to 0 after key_len-1; forced to 0 on start.
// - Config: key_we with key_addr >= MAX_KEY or key_data not in table -> no write, cfg_err. key_len_in==0 or
//   > MAX_KEY -> no write, cfg_err. Any config strobe outside IDLE -> no write, cfg_err.
//   key_we and key_len_we same cycle: both evaluated independently; cfg_err if either rejected.
// - key_len < key positions written: unused positions ignored. Key changes take effect on next start.
// - start and key write same IDLE cycle: write lands, start honoured; new key used from first char.
// - Async reset mid-message: all state as reset, key store and key_len back to default, pending output dropped.
// STRUCTURE
// - Package cipher_pkg: 5x5 table constant (MATEI/BCDFG/HKLNO/PQRSU/VWXYZ, no J), default key "PARASCHIV",
//   ERR_CHAR = 8'h3F, state enum {IDLE, RUN, FLUSH}, table lookup functions char->(row,col), (row,col)->char.
// - Sub-module nihilist_char_decode: combinational (in_data, key char) -> (plain char, err). Controller
//   holds FSM, key store, key_idx, output register, err_cnt.
// TESTING
// - Default key, start, stream 72,26,76 (last on 76), out_ready=1 -> H,E,L on consecutive cycles, out_last on L, done pulse.
// - key_len=1, key[0]="A"(12); stream 43,43,26 -> H,H,E; key_idx stays 0; no errors.
// - Default key, in_data=41 (41-41=0) -> out_data 8'h3F, out_err=1, err_cnt=1; next char 26 with key A -> E.
// - 10-char message with default key: 10th char uses key[0] (wrap); hold out_ready=0 4 cycles -> in_ready=0,
//   out_data stable, no loss or duplication.
// - In RUN: key_we, key_len_we=5 -> cfg_err pulses, key unchanged; in IDLE: key_len_in=0 and key_data="J" -> cfg_err.
// - Drop rst_n mid-message after 3 chars -> out_valid=0, busy=0 immediately; after release, start + 72 -> H (default key).

Source files
------------

// File: rtl/nihilist_stream_ctrl_pkg.sv
// Shared definitions for the Nihilist/Polybius stream decrypt controller.
// Holds the 5x5 Polybius table (no J), the power-on key, the error glyph,
// the controller state enum, and the table lookup helpers used by the
// controller (key validation) and the character decoder.
package nihilist_stream_ctrl_pkg;

    // Row-major 5x5 table, first character in the most significant byte.
    localparam logic [199:0] POLY_TABLE      = "MATEIBCDFGHKLNOPQRSUVWXYZ";
    localparam logic [71:0]  DEFAULT_KEY     = "PARASCHIV";
    localparam int           DEFAULT_KEY_LEN = 9;
    localparam logic [7:0]   ERR_CHAR        = 8'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Table coordinates of a character; row/col are 1..5 when found.
    typedef struct packed {
        logic       found;
        logic [2:0] row;
        logic [2:0] col;
    } poly_pos_t;

    function automatic poly_pos_t char_to_pos(input logic [7:0] ch);
        poly_pos_t pos;
        pos = '{found: 1'b0, row: 3'd0, col: 3'd0};
        for (int k = 0; k < 25; k++) begin
            if (POLY_TABLE[8*(24-k) +: 8] == ch) begin
                pos.found = 1'b1;
                pos.row   = 3'(k / 5 + 1);
                pos.col   = 3'(k % 5 + 1);
            end else begin
                pos = pos;
            end
        end
        return pos;
    endfunction

    function automatic logic in_table(input logic [7:0] ch);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (POLY_TABLE[8*(24-k) +: 8] == ch) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // Caller guarantees row/col in 1..5; anything else maps to the error glyph.
    function automatic logic [7:0] pos_to_char(input logic [2:0] row, input logic [2:0] col);
        int idx;
        idx = (int'(row) - 1) * 5 + (int'(col) - 1);
        if (idx < 0 || idx > 24) begin
            return ERR_CHAR;
        end else begin
            return POLY_TABLE[8*(24-idx) +: 8];
        end
    endfunction

    // Power-on key character for store position i (positions past the
    // default key fall back to 'A' so the store never holds an illegal char).
    function automatic logic [7:0] default_key_char(input int i);
        if (i < DEFAULT_KEY_LEN) begin
            return DEFAULT_KEY[8*(DEFAULT_KEY_LEN-1-i) +: 8];
        end else begin
            return 8'h41;
        end
    endfunction

endpackage

// File: rtl/nihilist_stream_ctrl_if.sv
// Ciphertext ingress and plaintext egress stream bundle.
// master: upstream FIFO / text sink side; slave: the controller.
//   in_valid/in_ready/in_data/in_last    ciphertext byte handshake
//   out_valid/out_ready/out_data/out_last/out_err  plaintext handshake
interface nihilist_stream_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_err;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_err
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_err
    );
endinterface

// File: rtl/nihilist_char_decode.sv
// Combinational single-character Nihilist decode.
//   cipher_i   ciphertext value (row*10+col sum)
//   key_char_i current key character (expected to be in the table)
//   plain_o    decoded plaintext, or ERR_CHAR on failure
//   err_o      decode failure: underflow, or row/col digit outside 1..5
module nihilist_char_decode
    import nihilist_stream_ctrl_pkg::*;
(
    input  logic [7:0] cipher_i,
    input  logic [7:0] key_char_i,
    output logic [7:0] plain_o,
    output logic       err_o
);
    poly_pos_t  key_pos_s;
    logic [7:0] ksum_s;
    logic [7:0] diff_s;
    logic [7:0] row_s;
    logic [7:0] col_s;

    // Strip the key contribution, split the remainder into two digits.
    always_comb begin
        key_pos_s = char_to_pos(key_char_i);
        ksum_s    = 8'(key_pos_s.row) * 8'd10 + 8'(key_pos_s.col);
        diff_s    = cipher_i - ksum_s;
        row_s     = diff_s / 8'd10;
        col_s     = diff_s % 8'd10;
        // Underflow is checked on the raw operands; diff_s is meaningless then.
        if (!key_pos_s.found || (cipher_i < ksum_s) ||
            (row_s < 8'd1) || (row_s > 8'd5) ||
            (col_s < 8'd1) || (col_s > 8'd5)) begin
            plain_o = ERR_CHAR;
            err_o   = 1'b1;
        end else begin
            plain_o = pos_to_char(row_s[2:0], col_s[2:0]);
            err_o   = 1'b0;
        end
    end
endmodule

// File: rtl/nihilist_stream_ctrl.sv
// Nihilist decrypt sequencing controller: message framing FSM, programmable
// key store, per-character key cycling, one-deep output register, error count.
//   clk, rst_n                 clock, async active-low reset
//   start / busy / done        message framing
//   key_we/key_addr/key_data   key character write (IDLE only)
//   key_len_we/key_len_in      key length write (IDLE only)
//   cfg_err                    one-cycle pulse on a rejected config write
//   err_cnt                    saturating decode-error count for the message
//   strm                       ciphertext in / plaintext out streams
module nihilist_stream_ctrl
    import nihilist_stream_ctrl_pkg::*;
#(
    parameter int MAX_KEY = 9,
    parameter int KIW     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  key_we,
    input  logic [KIW-1:0]        key_addr,
    input  logic [7:0]            key_data,
    input  logic                  key_len_we,
    input  logic [KIW-1:0]        key_len_in,
    output logic                  cfg_err,
    output logic [7:0]            err_cnt,
    nihilist_stream_ctrl_if.slave strm
);
    localparam int             DEF_LEN   = (MAX_KEY < DEFAULT_KEY_LEN) ? MAX_KEY : DEFAULT_KEY_LEN;
    localparam logic [KIW-1:0] MAX_KEY_K = KIW'(MAX_KEY);
    localparam logic [KIW-1:0] DEF_LEN_K = KIW'(DEF_LEN);

    state_t         state_q,     state_d;
    logic           busy_q,      busy_d;
    logic           done_q,      done_d;
    logic           cfg_err_q,   cfg_err_d;
    logic           out_valid_q, out_valid_d;
    logic [7:0]     out_data_q,  out_data_d;
    logic           out_last_q,  out_last_d;
    logic           out_err_q,   out_err_d;
    logic [7:0]     err_cnt_q,   err_cnt_d;
    logic [KIW-1:0] key_idx_q,   key_idx_d;
    logic [KIW-1:0] key_len_q,   key_len_d;
    logic [7:0]     key_q [MAX_KEY];
    logic [7:0]     key_d [MAX_KEY];

    logic           in_ready_s;
    logic           accept_s;
    logic           out_fire_s;
    logic           key_ok_s;
    logic           len_ok_s;
    logic [7:0]     dec_char_s;
    logic           dec_err_s;

    // Input is taken whenever the single output slot is free or draining.
    assign in_ready_s = (state_q == RUN) && (!out_valid_q || strm.out_ready);
    assign accept_s   = strm.in_valid && in_ready_s;
    assign out_fire_s = out_valid_q && strm.out_ready;

    nihilist_char_decode u_decode (
        .cipher_i   (strm.in_data),
        .key_char_i (key_q[key_idx_q]),
        .plain_o    (dec_char_s),
        .err_o      (dec_err_s)
    );

    // Next-state logic: config writes, output slot, FSM, key cycling, error count.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        err_cnt_d   = err_cnt_q;
        key_idx_d   = key_idx_q;
        key_len_d   = key_len_q;
        key_d       = key_q;

        // The two config strobes are judged independently.
        key_ok_s  = key_we && (state_q == IDLE) && (key_addr < MAX_KEY_K) && in_table(key_data);
        len_ok_s  = key_len_we && (state_q == IDLE) && (key_len_in != {KIW{1'b0}}) &&
                    (key_len_in <= MAX_KEY_K);
        cfg_err_d = (key_we && !key_ok_s) || (key_len_we && !len_ok_s);
        if (key_ok_s) begin
            key_d[key_addr] = key_data;
        end else begin
            key_d = key_d;
        end
        if (len_ok_s) begin
            key_len_d = key_len_in;
        end else begin
            key_len_d = key_len_q;
        end

        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = dec_char_s;
            out_err_d   = dec_err_s;
            out_last_d  = strm.in_last;
        end else if (out_fire_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    key_idx_d = {KIW{1'b0}};
                    err_cnt_d = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (accept_s) begin
                    if (key_idx_q == key_len_q - KIW'(1)) begin
                        key_idx_d = {KIW{1'b0}};
                    end else begin
                        key_idx_d = key_idx_q + KIW'(1);
                    end
                    if (dec_err_s && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    if (strm.in_last) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                // Stay busy until the last plaintext char leaves the slot.
                if (out_fire_s && out_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State registers; reset also restores the power-on key and length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
            key_idx_q   <= {KIW{1'b0}};
            key_len_q   <= DEF_LEN_K;
            for (int i = 0; i < MAX_KEY; i++) begin
                key_q[i] <= default_key_char(i);
            end
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
            err_cnt_q   <= err_cnt_d;
            key_idx_q   <= key_idx_d;
            key_len_q   <= key_len_d;
            key_q       <= key_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;
    assign err_cnt       = err_cnt_q;
    assign strm.in_ready  = in_ready_s;
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = out_data_q;
    assign strm.out_last  = out_last_q;
    assign strm.out_err   = out_err_q;
endmodule
